// File: rtl/lfsr_chk_pkg.sv
// lfsr_chk_pkg: shared state encoding, default thresholds and LFSR prediction for the PRBS checker
package lfsr_chk_pkg;
   typedef enum logic [1:0] {SEED = 2'd0, HUNT = 2'd1, LOCK = 2'd2} chk_state_e;
   localparam int DEF_LOCK_CNT = 16;
   localparam int DEF_WIN_LEN = 256;
   localparam int DEF_LOSS_THRESH = 4;
   function automatic logic lfsr_pred(input logic [31:0] h, input int n, input int t1, input int t2, input int t3);
      return ~(h[5'(n - 1)] ^ h[5'(t1 - 1)] ^ h[5'(t2 - 1)] ^ h[5'(t3 - 1)]);
   endfunction
endpackage

// File: rtl/lfsr_4tap_chk_if.sv
// lfsr_4tap_chk_if: serial pattern input and lock/error status of the PRBS checker
interface lfsr_4tap_chk_if #(parameter int ERR_W = 16);
   logic EN, DIN, CLR_ERR, LOCKED, ERR, STUCK;
   logic [ERR_W-1:0] ERR_CNT;
   modport master(output EN, DIN, CLR_ERR, input LOCKED, ERR, ERR_CNT, STUCK);
   modport slave(input EN, DIN, CLR_ERR, output LOCKED, ERR, ERR_CNT, STUCK);
endinterface

// File: rtl/lfsr_chk_errwin.sv
// lfsr_chk_errwin: loss-of-lock detector tallying errors over fixed windows of checked bits
module lfsr_chk_errwin
   import lfsr_chk_pkg::*;
#(
   parameter int WIN_LEN = DEF_WIN_LEN,
   parameter int LOSS_THRESH = DEF_LOSS_THRESH
) (
   input  logic CLK,
   input  logic RST,
   input  logic active,
   input  logic step,
   input  logic hit,
   output logic loss
);
   localparam int WB = $clog2(WIN_LEN);
   localparam int EB = $clog2(LOSS_THRESH + 1);
   logic [WB-1:0] wbit;
   logic [EB-1:0] werr;
   logic wrap;
   assign wrap = wbit == WB'(WIN_LEN - 1);
   assign loss = step && hit && werr == EB'(LOSS_THRESH - 1);
   // window position and per-window error tally, held at zero outside lock
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         wbit <= '0;
         werr <= '0;
      end else if (!active) begin
         wbit <= '0;
         werr <= '0;
      end else if (step) begin
         wbit <= wrap ? '0 : wbit + WB'(1);
         werr <= wrap ? '0 : werr + EB'(hit);
      end
endmodule

// File: rtl/lfsr_4tap_chk.sv
// lfsr_4tap_chk: self-synchronising 4-tap XNOR PRBS checker; LFSR_CHK_LOCKUP_DET_EN enables all-ones lockup detection
module lfsr_4tap_chk
   import lfsr_chk_pkg::*;
#(
   parameter int N = 8,
   parameter int FB_tap1 = 4,
   parameter int FB_tap2 = 5,
   parameter int FB_tap3 = 6,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int WIN_LEN = DEF_WIN_LEN,
   parameter int LOSS_THRESH = DEF_LOSS_THRESH,
   parameter int ERR_W = 16
) (
   input logic CLK,
   input logic RST,
   lfsr_4tap_chk_if.slave bus
);
   localparam int FW = $clog2(N + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   chk_state_e state, state_nxt;
   logic [N:1] hist, hist_nxt;
   logic [FW-1:0] fill, fill_nxt;
   logic [MW-1:0] match, match_nxt;
   logic stuck, stuck_nxt, pred, mis, loss, lockup, err;
   logic [ERR_W-1:0] err_cnt;
   assign pred = lfsr_pred(32'(hist), N, FB_tap1, FB_tap2, FB_tap3);
   assign mis = bus.EN && state == LOCK && bus.DIN != pred;
   assign bus.LOCKED = state == LOCK;
   assign bus.ERR = err;
   assign bus.ERR_CNT = err_cnt;
`ifdef LFSR_CHK_LOCKUP_DET_EN
   assign lockup = &hist && state != SEED;
   assign bus.STUCK = stuck;
`else
   assign lockup = 1'b0;
   assign bus.STUCK = 1'b0;
`endif
   lfsr_chk_errwin #(.WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH)) u_errwin (
      .CLK(CLK),
      .RST(RST),
      .active(state == LOCK),
      .step(bus.EN && state == LOCK),
      .hit(bus.DIN != pred),
      .loss(loss)
   );
   // sync FSM: fill history, hunt for consecutive matches, then flywheel the local copy
   always_comb begin
      state_nxt = state;
      hist_nxt = hist;
      fill_nxt = fill;
      match_nxt = match;
      stuck_nxt = stuck;
      if (bus.EN) begin
         hist_nxt = {hist[N-1:1], state == LOCK ? pred : bus.DIN};
         if (!bus.DIN) stuck_nxt = 1'b0;
         if (lockup) begin
            state_nxt = SEED;
            fill_nxt = '0;
            stuck_nxt = 1'b1;
         end else begin
            case (state)
               SEED: begin
                  fill_nxt = fill == FW'(N - 1) ? '0 : fill + FW'(1);
                  if (fill == FW'(N - 1)) begin
                     state_nxt = HUNT;
                     match_nxt = '0;
                  end
               end
               HUNT: begin
                  match_nxt = bus.DIN != pred ? '0 : match >= MW'(LOCK_CNT - 1) ? match : match + MW'(1);
                  if (bus.DIN == pred && match >= MW'(LOCK_CNT - 1) && !stuck) begin
                     state_nxt = LOCK;
                     match_nxt = '0;
                  end
               end
               LOCK: begin
                  if (loss) begin
                     state_nxt = SEED;
                     fill_nxt = '0;
                  end
               end
               default: begin
                  state_nxt = SEED;
                  fill_nxt = '0;
               end
            endcase
         end
      end
   end
   // state, history and hunt counters
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= SEED;
         hist <= '0;
         fill <= '0;
         match <= '0;
         stuck <= 1'b0;
      end else begin
         state <= state_nxt;
         hist <= hist_nxt;
         fill <= fill_nxt;
         match <= match_nxt;
         stuck <= stuck_nxt;
      end
   // error pulse and saturating error count; clear beats a coincident increment
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         err <= 1'b0;
         err_cnt <= '0;
      end else begin
         err <= mis;
         err_cnt <= bus.CLR_ERR ? '0 : (mis && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
      end
endmodule

// File: tb/tb_lfsr_4tap_chk.sv
// tb_lfsr_4tap_chk: directed checks of lock, error counting, loss/relock, saturation, stuck line and reset
module tb_lfsr_4tap_chk;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic en = 1'b0, din = 1'b0, clr = 1'b0;
   logic [7:0] g = 8'h00;
   int checks = 0, failures = 0;
   always #5 CLK = ~CLK;
   lfsr_4tap_chk_if #(.ERR_W(16)) bus ();
   lfsr_4tap_chk_if #(.ERR_W(4)) bus4 ();
   assign bus.EN = en;
   assign bus.DIN = din;
   assign bus.CLR_ERR = clr;
   assign bus4.EN = en;
   assign bus4.DIN = din;
   assign bus4.CLR_ERR = clr;
   lfsr_4tap_chk dut (.CLK(CLK), .RST(RST), .bus(bus));
   lfsr_4tap_chk #(.ERR_W(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

   task automatic step(input logic d, input logic e);
      din = d;
      en = e;
      @(posedge CLK);
      #1;
   endtask
   task automatic gen_bit(output logic b);
      b = ~(g[7] ^ g[3] ^ g[4] ^ g[5]);
      g = {g[6:0], b};
   endtask
   task automatic send(input logic flip);
      logic b;
      gen_bit(b);
      step(b ^ flip, 1'b1);
   endtask
   task automatic send_n(input int n);
      repeat (n) send(1'b0);
   endtask
   task automatic do_reset();
      RST = 1'b1;
      en = 1'b0;
      clr = 1'b0;
      din = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      g = 8'h00;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #2;
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", bus.LOCKED); end
      checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
      checks++; if (bus.ERR_CNT !== 16'd0) begin failures++; $display("FAIL reset_errcnt: got %0d expected 0", bus.ERR_CNT); end
      checks++; if (bus.STUCK !== 1'b0) begin failures++; $display("FAIL reset_stuck: got %b expected 0", bus.STUCK); end
      checks++; if (bus4.ERR_CNT !== 4'd0) begin failures++; $display("FAIL reset_errcnt4: got %0d expected 0", bus4.ERR_CNT); end
   endtask

   task automatic test_lock();
      int errs = 0, drops = 0;
      do_reset();
      send_n(23);
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL lock_early: got %b expected 0", bus.LOCKED); end
      send(1'b0);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL lock_24: got %b expected 1", bus.LOCKED); end
      repeat (1000) begin
         send(1'b0);
         if (bus.ERR !== 1'b0) errs++;
         if (bus.LOCKED !== 1'b1) drops++;
      end
      checks++; if (errs !== 0) begin failures++; $display("FAIL lock_err_pulses: got %0d expected 0", errs); end
      checks++; if (drops !== 0) begin failures++; $display("FAIL lock_drops: got %0d expected 0", drops); end
      checks++; if (bus.ERR_CNT !== 16'd0) begin failures++; $display("FAIL lock_errcnt: got %0d expected 0", bus.ERR_CNT); end
   endtask

   task automatic test_single_err();
      send(1'b1);
      checks++; if (bus.ERR !== 1'b1) begin failures++; $display("FAIL single_err_pulse: got %b expected 1", bus.ERR); end
      send(1'b0);
      checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL single_err_end: got %b expected 0", bus.ERR); end
      checks++; if (bus.ERR_CNT !== 16'd1) begin failures++; $display("FAIL single_err_cnt: got %0d expected 1", bus.ERR_CNT); end
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL single_err_locked: got %b expected 1", bus.LOCKED); end
   endtask

   task automatic test_loss();
      do_reset();
      send_n(24);
      send_n(10); send(1'b1);
      send_n(49); send(1'b1);
      send_n(49); send(1'b1);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL loss_three_held: got %b expected 1", bus.LOCKED); end
      send_n(49); send(1'b1);
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL loss_drop: got %b expected 0", bus.LOCKED); end
      checks++; if (bus.ERR !== 1'b1) begin failures++; $display("FAIL loss_err4: got %b expected 1", bus.ERR); end
      checks++; if (bus.ERR_CNT !== 16'd4) begin failures++; $display("FAIL loss_errcnt: got %0d expected 4", bus.ERR_CNT); end
      send_n(23);
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL relock_early: got %b expected 0", bus.LOCKED); end
      send(1'b0);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL relock_24: got %b expected 1", bus.LOCKED); end
      send_n(10); send(1'b1);
      send_n(89); send(1'b1);
      send_n(99); send(1'b1);
      send_n(99); send(1'b1);
      send_n(99); send(1'b1);
      send_n(99); send(1'b1);
      send_n(50);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL window_hold: got %b expected 1", bus.LOCKED); end
      checks++; if (bus.ERR_CNT !== 16'd10) begin failures++; $display("FAIL window_errcnt: got %0d expected 10", bus.ERR_CNT); end
   endtask

   task automatic test_saturation();
      do_reset();
      send_n(24);
      repeat (20) begin
         send(1'b1);
         send_n(99);
      end
      checks++; if (bus4.ERR_CNT !== 4'hF) begin failures++; $display("FAIL sat_errcnt4: got %0d expected 15", bus4.ERR_CNT); end
      checks++; if (bus.ERR_CNT !== 16'd20) begin failures++; $display("FAIL sat_errcnt16: got %0d expected 20", bus.ERR_CNT); end
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL sat_locked: got %b expected 1", bus.LOCKED); end
      clr = 1'b1;
      send(1'b1);
      clr = 1'b0;
      checks++; if (bus.ERR !== 1'b1) begin failures++; $display("FAIL clr_err_pulse: got %b expected 1", bus.ERR); end
      checks++; if (bus.ERR_CNT !== 16'd0) begin failures++; $display("FAIL clr_priority: got %0d expected 0", bus.ERR_CNT); end
      checks++; if (bus4.ERR_CNT !== 4'd0) begin failures++; $display("FAIL clr_priority4: got %0d expected 0", bus4.ERR_CNT); end
      send_n(60);
      send(1'b1);
      checks++; if (bus.ERR_CNT !== 16'd1) begin failures++; $display("FAIL post_clr_cnt: got %0d expected 1", bus.ERR_CNT); end
      clr = 1'b1;
      step(1'b0, 1'b0);
      clr = 1'b0;
      checks++; if (bus.ERR_CNT !== 16'd0) begin failures++; $display("FAIL clr_no_en: got %0d expected 0", bus.ERR_CNT); end
      checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL err_no_en: got %b expected 0", bus.ERR); end
   endtask

   task automatic test_stuck();
      do_reset();
      repeat (24) step(1'b1, 1'b1);
`ifdef LFSR_CHK_LOCKUP_DET_EN
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL stuck_locked: got %b expected 0", bus.LOCKED); end
      checks++; if (bus.STUCK !== 1'b1) begin failures++; $display("FAIL stuck_set: got %b expected 1", bus.STUCK); end
      step(1'b0, 1'b1);
      checks++; if (bus.STUCK !== 1'b0) begin failures++; $display("FAIL stuck_clear: got %b expected 0", bus.STUCK); end
      repeat (24) step(1'b1, 1'b1);
      checks++; if (bus.STUCK !== 1'b1) begin failures++; $display("FAIL stuck_reset_pre: got %b expected 1", bus.STUCK); end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (bus.STUCK !== 1'b0) begin failures++; $display("FAIL stuck_async_rst: got %b expected 0", bus.STUCK); end
      RST = 1'b0;
`else
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL ones_locked: got %b expected 1", bus.LOCKED); end
      checks++; if (bus.STUCK !== 1'b0) begin failures++; $display("FAIL ones_stuck: got %b expected 0", bus.STUCK); end
`endif
   endtask

   task automatic test_en_toggle();
      do_reset();
      repeat (23) begin
         send(1'b0);
         step(1'($urandom), 1'b0);
      end
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL en_lock_early: got %b expected 0", bus.LOCKED); end
      send(1'b0);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL en_lock_24: got %b expected 1", bus.LOCKED); end
      step(1'($urandom), 1'b0);
      checks++; if (bus.LOCKED !== 1'b1) begin failures++; $display("FAIL en_idle_locked: got %b expected 1", bus.LOCKED); end
      send(1'b1);
      checks++; if (bus.ERR_CNT !== 16'd1) begin failures++; $display("FAIL en_errcnt: got %0d expected 1", bus.ERR_CNT); end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (bus.LOCKED !== 1'b0) begin failures++; $display("FAIL async_rst_locked: got %b expected 0", bus.LOCKED); end
      checks++; if (bus.ERR_CNT !== 16'd0) begin failures++; $display("FAIL async_rst_errcnt: got %0d expected 0", bus.ERR_CNT); end
      checks++; if (bus.STUCK !== 1'b0) begin failures++; $display("FAIL async_rst_stuck: got %b expected 0", bus.STUCK); end
      checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL async_rst_err: got %b expected 0", bus.ERR); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_single_err();
      test_loss();
      test_saturation();
      test_stuck();
      test_en_toggle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
